// File: rtl/sdr_pkg.sv
// Shared receive-path types: sample, pair and word widths, the IQ pair layout
// and the pairing state machine states.
package sdr_pkg;
  localparam int SAMPLE_WIDTH  = 12;
  localparam int IQ_PAIR_WIDTH = 24;
  localparam int OUT_WIDTH     = 32;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] q;
    logic [SAMPLE_WIDTH-1:0] i;
  } iq_pair_t;

  typedef enum logic {
    IDLE   = 1'b0,
    HAVE_I = 1'b1
  } pair_state_t;
endpackage

// File: rtl/word_fifo.sv
// Synchronous show-ahead word FIFO. A push into a full FIFO is accepted when a
// pop happens in the same cycle; read data reads as zero while empty.
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/afe_rx_packer.sv
// AFE receive packer: registers the multiplexed ADC bus, pairs I/Q samples and packs
// 24-bit pairs densely into 32-bit words. Build option: AFE_RX_PACKER_TEST_PATTERN_EN.
module afe_rx_packer #(
  parameter int SAMPLE_WIDTH  = 12,
  parameter int IQ_PAIR_WIDTH = 24,
  parameter int OUT_WIDTH     = 32,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [SAMPLE_WIDTH-1:0] afe_rx_d,
  input  logic                    afe_rx_sel,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sync_err,
  output logic                    overflow,
  output logic [15:0]             drop_cnt
);
  import sdr_pkg::*;

  localparam int ACC_W  = OUT_WIDTH + IQ_PAIR_WIDTH;
  localparam int FILL_W = 6;
  localparam logic [FILL_W:0] PAIR_BITS = IQ_PAIR_WIDTH[FILL_W:0];
  localparam logic [FILL_W:0] WORD_BITS = OUT_WIDTH[FILL_W:0];

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [SAMPLE_WIDTH-1:0] d_p0;
  logic                    sel_p0;
  logic                    vld_p0;
  logic [SAMPLE_WIDTH-1:0] hold_i;
  pair_state_t             state_q;
  pair_state_t             state_d;
  logic                    pair_vld;
  logic                    seq_err;
  logic                    latch_i;
  iq_pair_t                pair_p1;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        acc_cat;
  logic [ACC_W-1:0]        pair_ext;
  logic [FILL_W-1:0]       fill;
  logic [FILL_W:0]         fill_sum;
  logic                    completes;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    pop;
  logic                    push;
  logic                    drop;

  // Stage p0: registered ADC bus; vld_p0 marks samples captured while enabled
  always_ff @(posedge clk) begin
    d_p0   <= afe_rx_d;
    sel_p0 <= afe_rx_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= en;
  end

  // Stage p1: pairing, packing and FIFO write
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pair_vld = 1'b0;
    seq_err  = 1'b0;
    latch_i  = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else if (vld_p0) begin
      case (state_q)
        IDLE: begin
          if (!sel_p0) begin
            latch_i = 1'b1;
            state_d = HAVE_I;
          end else begin
            seq_err = 1'b1;
          end
        end
        HAVE_I: begin
          if (sel_p0) begin
            pair_vld = 1'b1;
            state_d  = IDLE;
          end else begin
            latch_i = 1'b1;
            seq_err = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (latch_i) hold_i <= d_p0;
  end

`ifdef AFE_RX_PACKER_TEST_PATTERN_EN
  logic [SAMPLE_WIDTH-1:0] pat_cnt;

  always_ff @(posedge clk) begin
    if (rst || !en)    pat_cnt <= '0;
    else if (pair_vld) pat_cnt <= pat_cnt + 1'b1;
  end

  assign pair_p1 = '{q: ~pat_cnt, i: pat_cnt};
`else
  assign pair_p1 = '{q: d_p0, i: hold_i};
`endif

  // A pair that would complete a word into a full FIFO is dropped whole, so the
  // accumulator never holds a partial pair and the word stream stays aligned.
  assign pair_ext  = {{(ACC_W-IQ_PAIR_WIDTH){1'b0}}, pair_p1};
  assign acc_cat   = acc | (pair_ext << fill);
  assign fill_sum  = {1'b0, fill} + PAIR_BITS;
  assign completes = (fill_sum >= WORD_BITS);
  assign pop       = out_valid && out_ready;
  assign drop      = pair_vld && completes && fifo_full && !pop;
  assign push      = pair_vld && completes && !drop;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      acc  <= '0;
      fill <= '0;
    end else if (pair_vld && !drop) begin
      if (completes) begin
        acc  <= acc_cat >> OUT_WIDTH;
        fill <= fill_sum[FILL_W-1:0] - WORD_BITS[FILL_W-1:0];
      end else begin
        acc  <= acc_cat;
        fill <= fill_sum[FILL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_err <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      sync_err <= seq_err;
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc16(drop_cnt);
      end
    end
  end

  word_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (acc_cat[OUT_WIDTH-1:0]),
    .full  (fifo_full),
    .pop   (pop),
    .rdata (out_data),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
endmodule

// File: tb/tb_afe_rx_packer.sv
// Directed bench for afe_rx_packer: packing order, latency, sequencing errors,
// enable flush, overflow alignment and reset.
module tb_afe_rx_packer;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] afe_rx_d;
  logic        afe_rx_sel;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        sync_err;
  logic        overflow;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int sync_cnt = 0;
  logic [31:0] words[$];

`ifdef AFE_RX_PACKER_TEST_PATTERN_EN
  localparam logic [31:0] W0 = 32'h01FFF000;
  localparam logic [31:0] W1 = 32'hD002FFE0;
  localparam logic [31:0] W2 = 32'hFFC003FF;
  localparam logic [31:0] SYNC_W = 32'h01FFF000;
  localparam logic [31:0] OVF_W0 = 32'h01FFF000;
  localparam int I_BASE = 0;
`else
  localparam logic [31:0] W0 = 32'hBC456123;
  localparam logic [31:0] W1 = 32'h2DEF789A;
  localparam logic [31:0] W2 = 32'h67834501;
  localparam logic [31:0] SYNC_W = 32'h55444333;
  localparam logic [31:0] OVF_W0 = 32'h02FFE001;
  localparam int I_BASE = 1;
`endif

  afe_rx_packer dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .afe_rx_d   (afe_rx_d),
    .afe_rx_sel (afe_rx_sel),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sync_err   (sync_err),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) words.push_back(out_data);
    if (sync_err) sync_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [11:0] d);
    afe_rx_sel = s;
    afe_rx_d   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [11:0] i, input logic [11:0] q);
    drive(1'b0, i);
    drive(1'b1, q);
  endtask

  // Let the last Q be packed, then disable and let the FIFO drain.
  task automatic settle();
    afe_rx_sel = 1'b0;
    afe_rx_d   = '0;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic send_four();
    send_pair(12'h123, 12'h456);
    send_pair(12'hABC, 12'h789);
    send_pair(12'hDEF, 12'h012);
    send_pair(12'h345, 12'h678);
  endtask

  initial begin
    int wb;
    int sb;
    logic [287:0] stream;
    logic [23:0]  pr;
    logic [11:0]  iv;
    logic [11:0]  ei;

    rst = 1'b1; en = 1'b0; afe_rx_d = '0; afe_rx_sel = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic packing and latency
    wb = words.size(); sb = sync_cnt; en = 1'b1;
    drive(1'b0, 12'h123); drive(1'b1, 12'h456);
    drive(1'b0, 12'hABC); drive(1'b1, 12'h789);
    check("lat_t1_valid", 32'(out_valid), 32'd0);
    drive(1'b0, 12'hDEF);
    check("lat_t2_valid", 32'(out_valid), 32'd1);
    check("lat_t2_data", out_data, W0);
    drive(1'b1, 12'h012);
    send_pair(12'h345, 12'h678);
    settle();
    check("pack_nwords", 32'(words.size() - wb), 32'd3);
    check("pack_w0", words[wb], W0);
    check("pack_w1", words[wb+1], W1);
    check("pack_w2", words[wb+2], W2);
    check("pack_no_sync_err", 32'(sync_cnt - sb), 32'd0);

    // Sequencing errors: orphan Q, then a replaced I
    wb = words.size(); sb = sync_cnt; en = 1'b1;
    drive(1'b1, 12'h111); drive(1'b0, 12'h222);
    drive(1'b0, 12'h333); drive(1'b1, 12'h444);
    send_pair(12'h555, 12'h666);
    settle();
    check("seq_sync_pulses", 32'(sync_cnt - sb), 32'd2);
    check("seq_nwords", 32'(words.size() - wb), 32'd1);
    check("seq_w0", words[wb], SYNC_W);

    // Enable drop with a partial word pending
    wb = words.size(); sb = sync_cnt; en = 1'b1;
    send_pair(12'hAAA, 12'hBBB);
    drive(1'b0, 12'h000);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    send_four();
    settle();
    check("en_nwords", 32'(words.size() - wb), 32'd3);
    check("en_w0", words[wb], W0);
    check("en_w1", words[wb+1], W1);
    check("en_w2", words[wb+2], W2);

    // Overflow under backpressure, then alignment of the drained stream
    wb = words.size(); sb = sync_cnt; en = 1'b1; out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      iv = 12'(k);
      send_pair(iv, ~iv);
    end
    drive(1'b0, 12'd11);
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_valid_held", 32'(out_valid), 32'd1);
    check("ovf_data_held", out_data, OVF_W0);
    out_ready = 1'b1;
    drive(1'b1, ~12'd11);
    for (int k = 12; k <= 16; k++) begin
      iv = 12'(k);
      send_pair(iv, ~iv);
    end
    settle();
    check("ovf_nwords", 32'(words.size() - wb), 32'd9);
    check("ovf_drop_final", 32'(drop_cnt), 32'd4);
    check("ovf_no_sync_err", 32'(sync_cnt - sb), 32'd0);
    for (int w = 0; w < 9; w++) stream[w*32 +: 32] = words[wb+w];
    for (int p = 0; p < 12; p++) begin
      pr = stream[p*24 +: 24];
      ei = 12'(((p < 6) ? p + 1 : p + 5) - 1 + I_BASE);
      check($sformatf("ovf_pair%0d", p), 32'(pr), 32'({~ei, ei}));
    end

    // Reset with two words buffered
    wb = words.size(); en = 1'b1; out_ready = 1'b0;
    send_pair(12'h123, 12'h456);
    send_pair(12'hABC, 12'h789);
    send_pair(12'hDEF, 12'h012);
    drive(1'b0, 12'h345);
    check("rstw_valid_before", 32'(out_valid), 32'd1);
    en = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstw_valid", 32'(out_valid), 32'd0);
    check("rstw_data", out_data, 32'd0);
    check("rstw_overflow", 32'(overflow), 32'd0);
    check("rstw_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rstw_sync_err", 32'(sync_err), 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wb = words.size(); sb = sync_cnt; en = 1'b1;
    send_four();
    settle();
    check("post_rst_nwords", 32'(words.size() - wb), 32'd3);
    check("post_rst_w0", words[wb], W0);
    check("post_rst_w2", words[wb+2], W2);
    check("post_rst_drop_cnt", 32'(drop_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
